// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the dual-slot hazard scoreboard.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_SHADOW = 2'd1,
    ST_DRAIN  = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic valid;
    logic track;
    logic csr;
  } sb_entry_t;

  function automatic int sb_id_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_alloc.sv
// Lowest-free-two picker over the table valid vector; ID 0 is never offered.
module hazard_sb_alloc
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W  = sb_id_width(DEPTH)
) (
  input  logic [DEPTH-1:0] i_used,
  output logic [ID_W-1:0]  o_id_a,
  output logic [ID_W-1:0]  o_id_b,
  output logic             o_found_a,
  output logic             o_found_b
);

  logic [DEPTH-1:0] w_free;

  assign w_free = ~i_used & ~{{(DEPTH-1){1'b0}}, 1'b1};

  // Descending scan: each free hit demotes the previous best pick to slot B.
  always_comb begin
    o_id_a    = {ID_W{1'b0}};
    o_id_b    = {ID_W{1'b0}};
    o_found_a = 1'b0;
    o_found_b = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      o_id_b    = w_free[i] ? o_id_a    : o_id_b;
      o_found_b = w_free[i] ? o_found_a : o_found_b;
      o_id_a    = w_free[i] ? ID_W'(i)  : o_id_a;
      o_found_a = w_free[i] ? 1'b1      : o_found_a;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Dual-slot issue scoreboard: tracks in-flight IDs, blocks RAW/WAW hazards and
// serialises branches (shadow) and fences (drain until the table is empty).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int  DEPTH      = 8,
  parameter int  NUM_COMMIT = 4,
  parameter int  REG_ADDR_W = 5,
  localparam int ID_W       = sb_id_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 slot_valid_i,
  input  logic [2*REG_ADDR_W-1:0]    slot_rd_i,
  input  logic [2*REG_ADDR_W-1:0]    slot_rs1_i,
  input  logic [2*REG_ADDR_W-1:0]    slot_rs2_i,
  input  logic [1:0]                 slot_rd_we_i,
  input  logic [1:0]                 slot_csr_i,
  input  logic [1:0]                 slot_branch_i,
  input  logic [1:0]                 slot_fence_i,
  input  logic                       resolve_valid_i,
  input  logic                       flush_i,
  input  logic                       irq_req_i,
  input  logic [NUM_COMMIT-1:0]      commit_valid_i,
  input  logic [NUM_COMMIT*ID_W-1:0] commit_id_i,
  output logic [1:0]                 issue_o,
  output logic [2*ID_W-1:0]          issue_id_o,
  output logic [ID_W:0]              used_count_o,
  output logic                       full_o,
  output logic                       busy_o
);

  sb_entry_t             r_entry [DEPTH];
  logic [REG_ADDR_W-1:0] r_rd    [DEPTH];
  sb_state_e             r_state;
  logic [ID_W:0]         r_used_count;
  logic                  r_full;
  logic                  r_busy;

  logic [REG_ADDR_W-1:0] w_rd  [2];
  logic [REG_ADDR_W-1:0] w_rs1 [2];
  logic [REG_ADDR_W-1:0] w_rs2 [2];
  logic [1:0]            w_trk;
  logic [DEPTH-1:0]      w_valid, w_release, w_live, w_valid_nxt;
  logic [1:0]            w_haz;
  logic                  w_ab_haz;
  logic [ID_W-1:0]       w_id_a, w_id_b;
  logic                  w_found_a, w_found_b;
  logic [1:0]            w_grant;
  sb_state_e             w_state_nxt;
  logic [ID_W:0]         w_count_nxt;
  logic                  w_count_zero;

  // Entries hold rd only when it is a real write target, so rd==0 means "no rd".
  function automatic logic entry_hit(input logic [REG_ADDR_W-1:0] rs1, rs2, rd,
                                     input logic csr, input sb_entry_t e,
                                     input logic [REG_ADDR_W-1:0] e_rd);
    logic reg_hit;
    reg_hit = (e_rd != {REG_ADDR_W{1'b0}}) && ((rs1 == e_rd) || (rs2 == e_rd) || (rd == e_rd));
    return e.track && (reg_hit || (e.csr && csr));
  endfunction

  // Per-slot field unpacking.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_rd[s]  = slot_rd_i[s*REG_ADDR_W +: REG_ADDR_W];
      w_rs1[s] = slot_rs1_i[s*REG_ADDR_W +: REG_ADDR_W];
      w_rs2[s] = slot_rs2_i[s*REG_ADDR_W +: REG_ADDR_W];
      w_trk[s] = slot_rd_we_i[s] && (w_rd[s] != {REG_ADDR_W{1'b0}});
    end
  end

  // Same-cycle release bypass and hazard compare against live entries.
  always_comb begin
    w_haz = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i]   = r_entry[i].valid;
      w_release[i] = 1'b0;
      for (int p = 0; p < NUM_COMMIT; p++) begin
        w_release[i] = w_release[i] |
                       (commit_valid_i[p] && (commit_id_i[p*ID_W +: ID_W] == ID_W'(i)));
      end
      w_live[i] = w_valid[i] & ~w_release[i];
      for (int s = 0; s < 2; s++) begin
        w_haz[s] = w_haz[s] |
                   (w_live[i] & entry_hit(w_rs1[s], w_rs2[s], w_rd[s], slot_csr_i[s],
                                          r_entry[i], r_rd[i]));
      end
    end
  end

  assign w_ab_haz = (w_trk[0] && ((w_rs1[1] == w_rd[0]) || (w_rs2[1] == w_rd[0]) ||
                                  (w_rd[1] == w_rd[0]))) ||
                    (slot_csr_i[0] && slot_csr_i[1]);
  assign w_count_zero = (r_used_count == {(ID_W+1){1'b0}});

  hazard_sb_alloc #(.DEPTH(DEPTH), .ID_W(ID_W)) u_alloc (
    .i_used    (w_valid),
    .o_id_a    (w_id_a),
    .o_id_b    (w_id_b),
    .o_found_a (w_found_a),
    .o_found_b (w_found_b)
  );

  // Grant priority; B never issues without A.
  always_comb begin
    w_grant = 2'b00;
    if (rst || flush_i || irq_req_i || (r_state != ST_NORMAL) || !w_found_a || !slot_valid_i[0]) begin
      w_grant = 2'b00;
    end else if (slot_branch_i[0] || slot_fence_i[0]) begin
      w_grant = (!w_haz[0] && (!slot_fence_i[0] || w_count_zero)) ? 2'b01 : 2'b00;
    end else if (w_haz[0]) begin
      w_grant = 2'b00;
    end else if (slot_branch_i[1] || slot_fence_i[1] || !slot_valid_i[1] ||
                 w_haz[1] || w_ab_haz || !w_found_b) begin
      w_grant = 2'b01;
    end else begin
      w_grant = 2'b11;
    end
  end

  // Serialisation FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        if (w_grant[0] && slot_branch_i[0]) begin
          w_state_nxt = ST_SHADOW;
        end else if (slot_valid_i[0] && slot_fence_i[0] && !w_count_zero && !flush_i && !irq_req_i) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_NORMAL;
        end
      end
      ST_SHADOW: w_state_nxt = (resolve_valid_i || flush_i) ? ST_NORMAL : ST_SHADOW;
      ST_DRAIN:  w_state_nxt = (w_count_zero || flush_i) ? ST_NORMAL : ST_DRAIN;
      default:   w_state_nxt = ST_NORMAL;
    endcase
  end

  // Next valid vector and the status derived from it.
  always_comb begin
    w_valid_nxt         = w_live;
    w_valid_nxt[w_id_a] = w_valid_nxt[w_id_a] | w_grant[0];
    w_valid_nxt[w_id_b] = w_valid_nxt[w_id_b] | w_grant[1];
    w_count_nxt         = {(ID_W+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_count_nxt = w_count_nxt + {{ID_W{1'b0}}, w_valid_nxt[i]};
    end
  end

  // ID table: release and allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '{valid: 1'b0, track: 1'b0, csr: 1'b0};
        r_rd[i]    <= {REG_ADDR_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i].valid <= w_valid_nxt[i];
      end
      if (w_grant[0]) begin
        r_entry[w_id_a].track <= w_trk[0] | slot_csr_i[0];
        r_entry[w_id_a].csr   <= slot_csr_i[0];
        r_rd[w_id_a]          <= w_trk[0] ? w_rd[0] : {REG_ADDR_W{1'b0}};
      end
      if (w_grant[1]) begin
        r_entry[w_id_b].track <= w_trk[1] | slot_csr_i[1];
        r_entry[w_id_b].csr   <= slot_csr_i[1];
        r_rd[w_id_b]          <= w_trk[1] ? w_rd[1] : {REG_ADDR_W{1'b0}};
      end
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_NORMAL;
      r_used_count <= {(ID_W+1){1'b0}};
      r_full       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_used_count <= w_count_nxt;
      r_full       <= &(w_valid_nxt | {{(DEPTH-1){1'b0}}, 1'b1});
      r_busy       <= |w_valid_nxt;
    end
  end

  assign issue_o      = w_grant;
  assign issue_id_o   = {(w_grant[1] ? w_id_b : {ID_W{1'b0}}), (w_grant[0] ? w_id_a : {ID_W{1'b0}})};
  assign used_count_o = r_used_count;
  assign full_o       = r_full;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios plus random traffic
// checked against a set-based reference model of the issue rules.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  localparam int DEPTH = 8, NC = 4, RW = 5, IW = 3;
  localparam int M_NORMAL = 0, M_SHADOW = 1, M_DRAIN = 2;

  logic clk = 1'b0, rst;
  logic [1:0] slot_valid_i, slot_rd_we_i, slot_csr_i, slot_branch_i, slot_fence_i;
  logic [2*RW-1:0] slot_rd_i, slot_rs1_i, slot_rs2_i;
  logic resolve_valid_i, flush_i, irq_req_i;
  logic [NC-1:0] commit_valid_i;
  logic [NC*IW-1:0] commit_id_i;
  logic [1:0] issue_o;
  logic [2*IW-1:0] issue_id_o;
  logic [IW:0] used_count_o;
  logic full_o, busy_o;

  hazard_scoreboard #(.DEPTH(DEPTH), .NUM_COMMIT(NC), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .slot_valid_i(slot_valid_i), .slot_rd_i(slot_rd_i),
    .slot_rs1_i(slot_rs1_i), .slot_rs2_i(slot_rs2_i), .slot_rd_we_i(slot_rd_we_i),
    .slot_csr_i(slot_csr_i), .slot_branch_i(slot_branch_i), .slot_fence_i(slot_fence_i),
    .resolve_valid_i(resolve_valid_i), .flush_i(flush_i), .irq_req_i(irq_req_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .issue_o(issue_o),
    .issue_id_o(issue_id_o), .used_count_o(used_count_o), .full_o(full_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] g; int ida; int idb; int cnt; bit full; bit busy; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  bit sv[2], we[2], cs[2], br[2], fe[2];
  int rd[2], r1[2], r2[2];
  bit cv[NC];
  int cid[NC];
  bit resolve, flush, irq, rst_v;

  // Reference model: set of in-flight IDs with their destination/CSR attributes.
  bit m_valid[DEPTH], m_wr[DEPTH], m_csr[DEPTH];
  int m_rd[DEPTH];
  int m_state;

  task automatic check(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_wr[i] = 0; m_csr[i] = 0; m_rd[i] = 0;
    end
    m_state = M_NORMAL;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_valid[i];
    return c;
  endfunction

  function automatic bit released(int id);
    for (int p = 0; p < NC; p++) if (cv[p] && cid[p] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit conflict(int s);
    for (int i = 1; i < DEPTH; i++) begin
      if (m_valid[i] && !released(i)) begin
        if (m_wr[i] && (r1[s] == m_rd[i] || r2[s] == m_rd[i] || rd[s] == m_rd[i])) return 1'b1;
        if (m_csr[i] && cs[s]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    int fr[$];
    int cnt;
    bit ha, hb, ab;
    for (int id = 1; id < DEPTH; id++) if (!m_valid[id]) fr.push_back(id);
    cnt = m_count();
    ha = conflict(0);
    hb = conflict(1);
    ab = (we[0] && rd[0] != 0 && (r1[1] == rd[0] || r2[1] == rd[0] || rd[1] == rd[0])) ||
         (cs[0] && cs[1]);
    if (rst_v || flush || irq || m_state != M_NORMAL || fr.size() == 0 || !sv[0]) e.g = 2'b00;
    else if (br[0] || fe[0]) e.g = (!ha && (!fe[0] || cnt == 0)) ? 2'b01 : 2'b00;
    else if (ha) e.g = 2'b00;
    else if (br[1] || fe[1] || !sv[1] || hb || ab || fr.size() == 1) e.g = 2'b01;
    else e.g = 2'b11;
    e.ida = e.g[0] ? fr[0] : 0;
    e.idb = e.g[1] ? fr[1] : 0;
    e.cnt = cnt;
    e.full = (fr.size() == 0);
    e.busy = (cnt != 0);
    return e;
  endfunction

  function automatic void model_update(exp_t e);
    int cnt = m_count();
    case (m_state)
      M_NORMAL: begin
        if (e.g[0] && br[0]) m_state = M_SHADOW;
        else if (sv[0] && fe[0] && cnt != 0 && !flush && !irq) m_state = M_DRAIN;
      end
      M_SHADOW: if (resolve || flush) m_state = M_NORMAL;
      M_DRAIN:  if (cnt == 0 || flush) m_state = M_NORMAL;
      default:  m_state = M_NORMAL;
    endcase
    for (int id = 0; id < DEPTH; id++) if (released(id)) m_valid[id] = 0;
    for (int s = 0; s < 2; s++) begin
      if (e.g[s]) begin
        int id = (s == 0) ? e.ida : e.idb;
        m_valid[id] = 1; m_wr[id] = we[s] && rd[s] != 0; m_rd[id] = rd[s]; m_csr[id] = cs[s];
      end
    end
  endfunction

  task automatic apply();
    rst = rst_v;
    slot_valid_i = {sv[1], sv[0]};
    slot_rd_we_i = {we[1], we[0]};
    slot_csr_i = {cs[1], cs[0]};
    slot_branch_i = {br[1], br[0]};
    slot_fence_i = {fe[1], fe[0]};
    slot_rd_i = {RW'(rd[1]), RW'(rd[0])};
    slot_rs1_i = {RW'(r1[1]), RW'(r1[0])};
    slot_rs2_i = {RW'(r2[1]), RW'(r2[0])};
    resolve_valid_i = resolve; flush_i = flush; irq_req_i = irq;
    for (int p = 0; p < NC; p++) begin
      commit_valid_i[p] = cv[p];
      commit_id_i[p*IW +: IW] = IW'(cid[p]);
    end
  endtask

  task automatic step();
    exp_t e;
    apply();
    if (rst_v) model_clear();
    e = model_eval();
    q.push_back(e);
    @(posedge clk);
    if (rst_v) model_clear();
    else model_update(e);
    #1;
  endtask

  task automatic idle();
    for (int s = 0; s < 2; s++) begin
      sv[s] = 0; we[s] = 0; cs[s] = 0; br[s] = 0; fe[s] = 0; rd[s] = 0; r1[s] = 0; r2[s] = 0;
    end
    for (int p = 0; p < NC; p++) begin cv[p] = 0; cid[p] = 0; end
    resolve = 0; flush = 0; irq = 0;
  endtask

  task automatic set_slot(int s, int d, int a, int b, bit w, bit c = 0, bit bb = 0, bit f = 0);
    sv[s] = 1; rd[s] = d; r1[s] = a; r2[s] = b; we[s] = w; cs[s] = c; br[s] = bb; fe[s] = f;
  endtask

  task automatic release_all();
    int p = 0;
    idle();
    for (int id = 1; id < DEPTH; id++) begin
      if (m_valid[id] && p < NC) begin cv[p] = 1; cid[p] = id; p++; end
    end
    step();
  endtask

  task automatic fill(int n);
    for (int k = 0; k < DEPTH && m_count() < n; k++) begin
      idle(); set_slot(0, 0, 0, 0, 0); step();
    end
  endtask

  // Monitor: compares every DUT presentation against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("issue_o", issue_o, e.g);
        check("issue_id_a", issue_id_o[IW-1:0], e.ida);
        check("issue_id_b", issue_id_o[2*IW-1:IW], e.idb);
        check("used_count", used_count_o, e.cnt);
        check("full", full_o, e.full);
        check("busy", busy_o, e.busy);
      end
    end
  end

  initial begin
    model_clear();
    idle();
    rst_v = 1; apply();
    @(posedge clk); #1;
    step(); step();
    rst_v = 0;
    idle(); set_slot(0, 5, 0, 0, 1); set_slot(1, 0, 6, 0, 0); step();
    idle(); step();
    idle(); set_slot(0, 0, 5, 0, 0); set_slot(1, 0, 0, 0, 0); step();
    cv[0] = 1; cid[0] = 1; step();
    release_all();
    idle(); set_slot(0, 7, 0, 0, 1); set_slot(1, 0, 0, 7, 0); step();
    release_all();
    idle(); set_slot(0, 7, 0, 0, 1); set_slot(1, 7, 0, 0, 1); step();
    release_all();
    idle(); set_slot(0, 0, 0, 0, 0, 1); set_slot(1, 0, 0, 0, 0, 1); step();
    release_all();
    idle(); set_slot(0, 0, 1, 2, 0, 0, 1); set_slot(1, 3, 0, 0, 1); step();
    for (int k = 0; k < 3; k++) begin idle(); set_slot(0, 3, 0, 0, 1); set_slot(1, 4, 0, 0, 1); step(); end
    resolve = 1; step();
    resolve = 0; step();
    release_all();
    fill(3);
    idle(); set_slot(0, 0, 0, 0, 0, 0, 0, 1); step();
    for (int p = 0; p < 3; p++) begin cv[p] = 1; cid[p] = p + 1; end
    step();
    idle(); set_slot(0, 0, 0, 0, 0, 0, 0, 1); step();
    step();
    release_all();
    fill(6);
    idle(); set_slot(0, 0, 0, 0, 0); set_slot(1, 0, 0, 0, 0); step();
    step();
    cv[0] = 1; cid[0] = 2; step();
    idle(); rst_v = 1; step(); step();
    rst_v = 0;
    for (int p = 0; p < NC; p++) begin cv[p] = 1; cid[p] = p + 1; end
    step();
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst_v = ($urandom_range(0, 299) == 0);
      for (int s = 0; s < 2; s++) begin
        sv[s] = ($urandom_range(0, 3) != 0);
        rd[s] = $urandom_range(0, 7); r1[s] = $urandom_range(0, 7); r2[s] = $urandom_range(0, 7);
        we[s] = $urandom_range(0, 1);
        cs[s] = ($urandom_range(0, 15) == 0);
        br[s] = ($urandom_range(0, 11) == 0);
        fe[s] = ($urandom_range(0, 19) == 0);
      end
      for (int p = 0; p < NC; p++) begin
        cv[p] = $urandom_range(0, 1);
        cid[p] = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 1) == 1) begin
          for (int id = 1; id < DEPTH; id++) if (m_valid[id] && $urandom_range(0, 2) == 0) cid[p] = id;
        end
      end
      resolve = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 39) == 0);
      irq = ($urandom_range(0, 39) == 0);
      step();
    end
    idle(); rst_v = 0; step();
    @(negedge clk); #1;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
